fxp8s_result_sink: RTL

Downstream consumer of the 3x3 FXP8S processing-element array's result stream. It accepts one DIM x DIM result matrix (row-major, sign-magnitude 8-bit) over a valid/ready handshake and stores it in a local buffer. It applies optional ReLU and negative-zero normalisation, then re-emits the matrix row-major or transposed on a downstream valid/ready stream with row and matrix framing flags. The block is single-buffered: fill and drain never overlap.

---
 rtl/fxp8s_result_sink_if.sv | 26 ++
 rtl/fxp8s_result_sink.sv | 114 +++++++++++
 2 files changed

// File: rtl/fxp8s_result_sink_if.sv
// Valid/ready bundle between the PE result stream, the sink and its consumer.
// The sink sits on the slave modport; the driving side uses master.
interface fxp8s_result_sink_if #(
    parameter int WIDTH = 8
);
    logic             en_in_data;
    logic             rdy_in_data;
    logic [WIDTH-1:0] in_data;
    logic             en_out_data;
    logic             rdy_out_data;
    logic [WIDTH-1:0] out_data;
    logic             out_new_row;
    logic             out_mat_done;

    modport master (
        output en_in_data, in_data, rdy_out_data,
        input  rdy_in_data, en_out_data, out_data,
        input  out_new_row, out_mat_done
    );

    modport slave (
        input  en_in_data, in_data, rdy_out_data,
        output rdy_in_data, en_out_data, out_data,
        output out_new_row, out_mat_done
    );
endinterface

// File: rtl/fxp8s_result_sink.sv
// Single-buffered DIMxDIM result sink: fill, ReLU/neg-zero cleanup,
// then drain row-major or transposed with row/matrix framing.
module fxp8s_result_sink #(
    parameter int DIM   = 3,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_relu,
    input  logic                 cfg_transpose,
    output logic                 busy,
    fxp8s_result_sink_if.slave   s
);
    localparam int N  = DIM * DIM;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_wr_idx;
    logic [AW-1:0]    r_r;
    logic [AW-1:0]    r_c;
    logic             r_relu_q;
    logic             r_tr_q;
    logic [WIDTH-1:0] r_mem [N];

    logic             w_acc;
    logic             w_xfer;
    logic             w_first;
    logic             w_last_in;
    logic             w_rlast;
    logic             w_clast;
    logic             w_relu;
    logic [WIDTH-1:0] w_negz;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_addr;

    assign s.rdy_in_data = rstn & (r_state == FILL);
    assign s.en_out_data = (r_state == DRAIN);
    assign busy          = (r_state == DRAIN);

    assign w_acc     = s.en_in_data & s.rdy_in_data;
    assign w_xfer    = s.en_out_data & s.rdy_out_data;
    assign w_first   = (r_wr_idx == '0);
    assign w_last_in = (r_wr_idx == AW'(N - 1));
    assign w_rlast   = (r_r == AW'(DIM - 1));
    assign w_clast   = (r_c == AW'(DIM - 1));

    // First element of a matrix sees the live cfg; the rest see the latched copy.
    assign w_relu  = w_first ? cfg_relu : r_relu_q;
    assign w_negz  = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_wdata = (w_relu & s.in_data[WIDTH-1]) ? '0 :
                     (s.in_data == w_negz)         ? '0 :
                                                     s.in_data;

    assign w_addr = r_tr_q ? AW'(r_c * DIM + r_r)
                           : AW'(r_r * DIM + r_c);

    assign s.out_data     = s.en_out_data ? r_mem[w_addr] : '0;
    assign s.out_new_row  = s.en_out_data & (r_c == '0);
    assign s.out_mat_done = s.en_out_data & w_rlast & w_clast;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[r_wr_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= FILL;
            r_wr_idx <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_relu_q <= 1'b0;
            r_tr_q   <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_acc) begin
                        if (w_first) begin
                            r_relu_q <= cfg_relu;
                            r_tr_q   <= cfg_transpose;
                        end
                        if (w_last_in) begin
                            r_wr_idx <= '0;
                            r_state  <= DRAIN;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        if (w_clast) begin
                            r_c <= '0;
                            if (w_rlast) begin
                                r_r     <= '0;
                                r_state <= FILL;
                            end else begin
                                r_r <= r_r + 1'b1;
                            end
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
